// File: rtl/if_fetch_buf.sv
// if_fetch_buf: instruction fetch buffer between the PC stage and decode.
// Each accepted memory request reserves an entry in program order. In-order
// responses fill those entries, and decode pops them. A flush discards every
// buffered entry and drops the responses that are still in flight.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a response
// that targets the head entry is forwarded to decode in the same cycle.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module if_fetch_buf #(
  parameter int DEPTH      = 4,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [`CPU_WIDTH-1:0] curr_pc,
  output logic                  pc_adv,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [`CPU_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  flush,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic [`CPU_WIDTH-1:0] id_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  // The discard counter can build up across back-to-back flushes, so it is
  // given extra headroom beyond the entry count.
  localparam int DW = AW + 4;

  logic [`CPU_WIDTH-1:0] pc_q   [DEPTH];
  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]      filled_q, filled_d;
  logic [AW-1:0]         alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d, pend_q, pend_d;
  logic [DW-1:0]         disc_q, disc_d;

  logic alloc_now, fill_now, drop, byp, pop;

  assign imem_req_valid = ena & ~flush & ~rst & (count_q < CW'(DEPTH));
  assign imem_req_addr  = curr_pc;
  assign alloc_now      = imem_req_valid & imem_req_ready;
  assign pc_adv         = alloc_now;

  // A response fills an entry only when no flushed fetch is left to drop and
  // an entry is waiting for data. Any other response is a stray and is ignored.
  assign drop     = imem_rsp_valid & (disc_q != '0);
  assign fill_now = imem_rsp_valid & (disc_q == '0) & (pend_q != '0);

`ifdef FETCH_BYPASS_EN
  assign byp = fill_now & (fill_q == rd_q) & ~filled_q[rd_q];
`else
  assign byp = 1'b0;
`endif

  assign id_valid = (filled_q[rd_q] | byp) & ~flush & ~rst;
  assign id_inst  = id_valid ? (byp ? imem_rsp_data : inst_q[rd_q]) : '0;
  assign id_pc    = id_valid ? pc_q[rd_q] : '0;
  assign pop      = id_valid & id_ready;

  // Next-state logic for the pointers, the occupancy counts and the filled bits.
  always_comb begin
    filled_d = filled_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    rd_d     = rd_q;
    count_d  = count_q;
    pend_d   = pend_q;
    disc_d   = disc_q;
    if (flush) begin
      // Every allocated entry that is not yet filled still has a response on
      // the way. Those responses join the ones already queued for dropping.
      filled_d = '0;
      alloc_d  = '0;
      fill_d   = '0;
      rd_d     = '0;
      count_d  = '0;
      pend_d   = '0;
      disc_d   = disc_q - DW'(drop) + DW'(pend_q) - DW'(fill_now);
    end else begin
      // A bypassed entry that is popped in the same cycle is never retained.
      if (fill_now && !(byp && pop)) filled_d[fill_q] = 1'b1;
      if (pop) filled_d[rd_q] = 1'b0;
      if (alloc_now) alloc_d = alloc_q + AW'(1);
      if (fill_now)  fill_d  = fill_q + AW'(1);
      if (pop)       rd_d    = rd_q + AW'(1);
      count_d = count_q + CW'(alloc_now) - CW'(pop);
      pend_d  = pend_q + CW'(alloc_now) - CW'(fill_now);
      if (drop) disc_d = disc_q - DW'(1);
    end
  end

  // Control state register. Reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      filled_q <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      disc_q   <= '0;
    end else begin
      filled_q <= filled_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      disc_q   <= disc_d;
    end
  end

  // Entry payload storage. It is not reset, because the filled bits guard every read.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (alloc_now) pc_q[alloc_q]  <= curr_pc;
      if (fill_now)  inst_q[fill_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_buf.sv
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module tb_if_fetch_buf;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ena, flush, imem_req_ready, imem_rsp_valid, id_ready;
  logic [31:0] curr_pc, imem_rsp_data;
  logic        pc_adv, imem_req_valid, id_valid;
  logic [31:0] imem_req_addr, id_inst, id_pc;

  if_fetch_buf #(.DEPTH(DEPTH), .INST_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ena(ena), .curr_pc(curr_pc), .pc_adv(pc_adv),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .flush(flush), .id_valid(id_valid),
    .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of allocated entries: expected pc, expected inst, filled flag.
  logic [31:0] sb_pc[$];
  logic [31:0] sb_inst[$];
  bit          sb_filled[$];
  // Memory model: accepted addresses in order. Stale ones belong to fetches
  // that were flushed away.
  logic [31:0] mq_addr[$];
  bit          mq_stale[$];
  bit          mem_hold  = 1'b0;
  bit          stray     = 1'b0;
  bit          rsp_stale = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one clock cycle. Outputs are checked at the negedge, the model is
  // updated, and the memory response and PC are then driven after the posedge.
  task automatic cycle();
    bit exp_rv, fill_now, exp_idv, popped, adv;
    int fill_idx;
    @(negedge clk);
    exp_rv = ena && !flush && !rst && (sb_pc.size() < DEPTH);
    adv    = exp_rv && imem_req_ready;
    check("req_valid", imem_req_valid, exp_rv);
    check("pc_adv", pc_adv, adv);
    check("req_addr", imem_req_addr, curr_pc);
    fill_idx = -1;
    foreach (sb_filled[i]) if (!sb_filled[i] && fill_idx < 0) fill_idx = i;
    fill_now = imem_rsp_valid && !rsp_stale && !flush && !rst && (fill_idx >= 0);
    exp_idv  = !rst && !flush && (sb_pc.size() > 0) &&
               (sb_filled[0] || (BYP && fill_now && fill_idx == 0));
    check("id_valid", id_valid, exp_idv);
    if (exp_idv) begin
      check("id_pc", id_pc, sb_pc[0]);
      check("id_inst", id_inst, sb_inst[0]);
    end
    if (rst) begin
      check("rst_id_pc", id_pc, 0);
      check("rst_id_inst", id_inst, 0);
    end
    popped = exp_idv && id_ready;
    if (popped) begin
      $display("pop  pc=%08h inst=%08h", sb_pc[0], sb_inst[0]);
      void'(sb_pc.pop_front());
      void'(sb_inst.pop_front());
      void'(sb_filled.pop_front());
    end
    if (fill_now) begin
      fill_idx = fill_idx - int'(popped);
      if (fill_idx >= 0) sb_filled[fill_idx] = 1'b1;
    end
    if (adv) begin
      $display("req  pc=%08h", curr_pc);
      sb_pc.push_back(curr_pc);
      sb_inst.push_back(~curr_pc);
      sb_filled.push_back(1'b0);
      mq_addr.push_back(curr_pc);
      mq_stale.push_back(1'b0);
    end
    if (flush) begin
      sb_pc.delete(); sb_inst.delete(); sb_filled.delete();
      foreach (mq_stale[i]) mq_stale[i] = 1'b1;
    end
    if (rst) begin
      sb_pc.delete(); sb_inst.delete(); sb_filled.delete();
      mq_addr.delete(); mq_stale.delete();
    end
    @(posedge clk);
    #1;
    if (adv) curr_pc = curr_pc + 32'd4;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rsp_stale      = 1'b0;
    if (!mem_hold && mq_addr.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mq_addr[0];
      rsp_stale      = mq_stale[0];
      void'(mq_addr.pop_front());
      void'(mq_stale.pop_front());
    end else if (stray) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
      rsp_stale      = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; flush = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
    curr_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #1;
    repeat (2) cycle();
    rst = 1'b0;

    // Streaming from pc 0 with decode always ready.
    ena = 1'b1;
    repeat (10) cycle();
    ena = 1'b0;
    repeat (4) cycle();

    // Decode stalled: the buffer fills to DEPTH, then requests stop.
    id_ready = 1'b0; ena = 1'b1;
    repeat (8) cycle();
    id_ready = 1'b1;
    repeat (3) cycle();
    ena = 1'b0;
    repeat (5) cycle();

    // Flush with two fetches in flight and one filled entry.
    id_ready = 1'b0; mem_hold = 1'b1; ena = 1'b1;
    repeat (3) cycle();
    ena = 1'b0; mem_hold = 1'b0;
    cycle();
    mem_hold = 1'b1;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0; mem_hold = 1'b0; curr_pc = 32'h100; ena = 1'b1; id_ready = 1'b1;
    cycle();
    ena = 1'b0;
    repeat (6) cycle();

    // Memory not ready for three cycles.
    ena = 1'b1; imem_req_ready = 1'b0;
    repeat (3) cycle();
    imem_req_ready = 1'b1;
    repeat (4) cycle();
    ena = 1'b0;
    repeat (5) cycle();

    // Reset with three filled entries.
    id_ready = 1'b0; ena = 1'b1;
    repeat (3) cycle();
    ena = 1'b0;
    repeat (3) cycle();
    rst = 1'b1; ena = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    ena = 1'b0; id_ready = 1'b1;
    repeat (5) cycle();

    // Single fetch into an empty buffer (bypass-latency case).
    curr_pc = 32'h2152_4110; ena = 1'b1;
    cycle();
    ena = 1'b0;
    repeat (4) cycle();

    // A stray response with nothing pending must be ignored.
    stray = 1'b1;
    cycle();
    stray = 1'b0;
    repeat (3) cycle();

    // Randomized traffic with flushes, resets and memory stalls.
    repeat (400) begin
      ena            = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 19) == 0);
      rst            = ($urandom_range(0, 59) == 0);
      mem_hold       = ($urandom_range(0, 3) == 0);
      cycle();
    end
    flush = 1'b0; rst = 1'b0; mem_hold = 1'b0; ena = 1'b0; id_ready = 1'b1;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_buf.md
IF_FETCH_BUF -- requirements
Module: if_fetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of fetch-buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter INST_WIDTH, default 32, meaning instruction word width.
REQ-003 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port ena  in  1  fetch enable from PC register.
REQ-006 SHALL have port curr_pc  in  `CPU_WIDTH  current program counter.
REQ-007 SHALL have port pc_adv  out  1  request accepted this cycle; next-PC logic advances PC.
REQ-008 SHALL have ports imem_req_valid out 1 / imem_req_ready in 1 / imem_req_addr out `CPU_WIDTH  instruction-memory request channel.
REQ-009 SHALL have ports imem_rsp_valid in 1 / imem_rsp_data in INST_WIDTH  in-order memory response, no backpressure.
REQ-010 SHALL have port flush  in  1  redirect; discard all buffered and in-flight fetches.
REQ-011 SHALL have ports id_valid out 1 / id_ready in 1 / id_inst out INST_WIDTH / id_pc out `CPU_WIDTH  decode-side channel.

Function
REQ-012 SHALL track per entry: pc, inst, filled bit; pointers alloc, fill, read; occupancy count of allocated entries (filled or pending).
REQ-013 SHALL drive imem_req_valid = ena & !flush & !rst & (count < DEPTH); imem_req_addr = curr_pc combinationally.
REQ-014 SHALL, on imem_req_valid & imem_req_ready, allocate entry at alloc with pc=curr_pc, filled=0, and assert pc_adv the same cycle.
REQ-015 SHALL, on imem_rsp_valid with discard counter zero, write imem_rsp_data into entry at fill, set filled, advance fill.
REQ-016 SHALL drive id_valid = filled bit of entry at read; id_inst/id_pc from that entry; pop on id_valid & id_ready.
REQ-017 SHALL support allocate, fill and pop in the same cycle; count = count + alloc - pop.
REQ-018 SHALL wrap all pointers modulo DEPTH.
REQ-019 SHALL, on flush, clear all filled bits, reset alloc/fill/read/count to 0, load discard counter with number of in-flight requests (allocated, unfilled), and suppress id_valid and pc_adv that cycle.
REQ-020 SHALL drop each imem_rsp_valid while discard counter nonzero and decrement it; new requests may issue during discard, with responses mapped after discards drain.
REQ-021 SHALL ignore id_ready while id_valid is low; id_inst/id_pc SHALL be stable while id_valid & !id_ready.
REQ-022 SHALL treat imem_rsp_valid with no pending entry and zero discard counter as a protocol error and ignore it.

Reset
REQ-023 SHALL, with rst high at a clock edge, clear pointers, count, discard counter and filled bits; outputs pc_adv=0, imem_req_valid=0, id_valid=0, imem_req_addr=curr_pc, id_inst=0, id_pc=0.
REQ-024 SHALL treat rst mid-operation identically to power-on; in-flight responses after reset are not the block's responsibility.
REQ-025 SHALL give rst priority over flush and all handshakes.

Configuration
REQ-026 SHALL use macro FETCH_BYPASS_EN.
REQ-027 SHALL, with FETCH_BYPASS_EN defined, when the read entry is the fill target, imem_rsp_valid, and discard zero, drive id_valid=1 with id_inst=imem_rsp_data that cycle; if popped, entry is not retained (zero-cycle latency).
REQ-028 SHALL, without FETCH_BYPASS_EN, present responses only from registered entries (response-to-id_valid latency one cycle).

Verification
REQ-029 SHALL cover: reset, ena=1, curr_pc=0x0, imem ready always, 1-cycle memory, id_ready=1 -> id_pc 0x0,0x4,0x8 in order, one per cycle after fill latency.
REQ-030 SHALL cover: id_ready=0 with continuous fetch -> exactly DEPTH=4 requests, then imem_req_valid=0 and pc_adv=0 until a pop.
REQ-031 SHALL cover: flush with 2 requests in flight and 1 filled entry -> id_valid=0 next cycle, next 2 responses dropped, first fetch after flush (curr_pc=0x100) delivered with id_pc=0x100.
REQ-032 SHALL cover: imem_req_ready=0 for 3 cycles -> pc_adv=0 those cycles, imem_req_addr held at curr_pc.
REQ-033 SHALL cover: rst asserted with 3 filled entries -> next cycle id_valid=0, count 0, imem_req_valid follows ena.
REQ-034 SHALL cover: FETCH_BYPASS_EN defined, empty buffer, response 0xDEADBEEF -> id_valid=1, id_inst=0xDEADBEEF same cycle; undefined -> one cycle later.
